// File: rtl/ysyx_24100006_mem_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24100006_mem_pkg
// Shared definitions for the memory-access stage:
//   - memu_state_e : MEM stage FSM states
//   - MEM_*        : sram_read_write operation encodings
//   - MASK_*       : funct3 access-width encodings (Mem_Mask)
//   - EXC_*        : exception codes reported on exc_code_o
//   - access_size  : collapses funct3 into byte / half / word
// ----------------------------------------------------------------------------
package ysyx_24100006_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } memu_state_e;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT     = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT    = 4'd7;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // funct3[1:0] carries the width; funct3[2] only selects zero-extension.
    // Unused encodings fall back to a word access.
    function automatic logic [1:0] access_size(input logic [2:0] mask);
        logic [1:0] sz;
        case (mask[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/ysyx_24100006_lsu_align.sv
// ----------------------------------------------------------------------------
// ysyx_24100006_lsu_align
// Purely combinational alignment helper for the MEM stage.
//   Store side (uses the instruction being accepted):
//     st_addr_lo_i, st_mask_i, st_data_i -> misaligned_o, st_wdata_o, st_wstrb_o
//   Load side (uses the latched access and the bus read data):
//     ld_addr_lo_i, ld_mask_i, ld_rdata_i -> ld_data_o (aligned + extended)
// ----------------------------------------------------------------------------
module ysyx_24100006_lsu_align
    import ysyx_24100006_mem_pkg::*;
(
    input  logic [1:0]  st_addr_lo_i,
    input  logic [2:0]  st_mask_i,
    input  logic [31:0] st_data_i,
    output logic        misaligned_o,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [2:0]  ld_mask_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [1:0]  st_size;
    logic [1:0]  ld_size;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_unsigned;

    // Store data is replicated across lanes so the strobes alone pick the
    // bytes that land; this keeps the shifter out of the data path.
    always_comb begin
        st_size      = access_size(st_mask_i);
        misaligned_o = 1'b0;
        st_wdata_o   = st_data_i;
        st_wstrb_o   = 4'b1111;
        case (st_size)
            SZ_BYTE: begin
                st_wdata_o = {4{st_data_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_addr_lo_i;
            end
            SZ_HALF: begin
                st_wdata_o   = {2{st_data_i[15:0]}};
                st_wstrb_o   = 4'b0011 << st_addr_lo_i;
                misaligned_o = st_addr_lo_i[0];
            end
            default: begin
                misaligned_o = |st_addr_lo_i;
            end
        endcase
    end

    always_comb begin
        ld_size     = access_size(ld_mask_i);
        ld_unsigned = ld_mask_i[2];
        ld_byte     = ld_rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
        ld_half     = ld_rdata_i[{ld_addr_lo_i[1], 4'b0000} +: 16];
        case (ld_size)
            SZ_BYTE: ld_data_o = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/ysyx_24100006_memu.sv
// ----------------------------------------------------------------------------
// ysyx_24100006_memu
// Memory-access pipeline stage. Accepts one instruction from EXE/MEM
// (in_valid/in_ready), issues at most one load/store on a single-outstanding
// request/response bus, and presents the result to MEM/WB (out_valid/out_ready).
//   clk, reset (async, active-low)
//   EXE/MEM : in_valid, in_ready, alu_result_i, sram_read_write_i, Mem_Mask_i,
//             wdata_gpr_i, wdata_csr_i, Gpr_Write_i, Gpr_Write_Addr_i,
//             Csr_Write_i, Csr_Write_Addr_i, is_break_i, flush_i
//   Bus     : req_valid, req_ready, req_wen, req_addr, req_wdata, req_wstrb,
//             rsp_valid, rsp_rdata, rsp_err
//   MEM/WB  : out_valid, out_ready, wdata_gpr_o, Gpr_Write_o, Gpr_Write_Addr_o,
//             Csr_Write_o, Csr_Write_Addr_o, wdata_csr_o, is_break_o,
//             exc_o, exc_code_o
// ----------------------------------------------------------------------------
module ysyx_24100006_memu
    import ysyx_24100006_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result_i,
    input  logic [1:0]  sram_read_write_i,
    input  logic [2:0]  Mem_Mask_i,
    input  logic [31:0] wdata_gpr_i,
    input  logic [31:0] wdata_csr_i,
    input  logic        Gpr_Write_i,
    input  logic [3:0]  Gpr_Write_Addr_i,
    input  logic        Csr_Write_i,
    input  logic [11:0] Csr_Write_Addr_i,
    input  logic        is_break_i,
    input  logic        flush_i,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_wen,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_wstrb,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata,
    input  logic        rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wdata_gpr_o,
    output logic        Gpr_Write_o,
    output logic [3:0]  Gpr_Write_Addr_o,
    output logic        Csr_Write_o,
    output logic [11:0] Csr_Write_Addr_o,
    output logic [31:0] wdata_csr_o,
    output logic        is_break_o,
    output logic        exc_o,
    output logic [3:0]  exc_code_o
);

    memu_state_e state_q, state_d;
    logic        drop_q, drop_d;

    logic        accept;
    logic        is_load_in;
    logic        is_mem_in;
    logic        misaligned;
    logic        mis_exc;
    logic        rsp_fire;
    memu_state_e accept_target;

    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] ld_data;

    // Latched access descriptor, needed to post-process the response.
    logic        is_load_q;
    logic [2:0]  mask_q;
    logic [1:0]  addr_lo_q;

    logic        req_wen_q;
    logic [31:0] req_addr_q;
    logic [31:0] req_wdata_q;
    logic [3:0]  req_wstrb_q;

    logic [31:0] wdata_gpr_q;
    logic        gpr_write_q;
    logic [3:0]  gpr_write_addr_q;
    logic        csr_write_q;
    logic [11:0] csr_write_addr_q;
    logic [31:0] wdata_csr_q;
    logic        is_break_q;
    logic        exc_q;
    logic [3:0]  exc_code_q;

    ysyx_24100006_lsu_align u_align (
        .st_addr_lo_i (alu_result_i[1:0]),
        .st_mask_i    (Mem_Mask_i),
        .st_data_i    (wdata_gpr_i),
        .misaligned_o (misaligned),
        .st_wdata_o   (st_wdata),
        .st_wstrb_o   (st_wstrb),
        .ld_addr_lo_i (addr_lo_q),
        .ld_mask_i    (mask_q),
        .ld_rdata_i   (rsp_rdata),
        .ld_data_o    (ld_data)
    );

    // Reserved op 2'b11 falls through as a non-memory op.
    assign is_load_in    = (sram_read_write_i == MEM_LOAD);
    assign is_mem_in     = is_load_in || (sram_read_write_i == MEM_STORE);
    assign mis_exc       = is_mem_in && misaligned;
    assign accept        = in_valid && in_ready;
    assign rsp_fire      = (state_q == S_WAIT) && rsp_valid;
    assign accept_target = (is_mem_in && !misaligned) ? S_REQ : S_HOLD;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // A flush during REQ/WAIT cannot abort the bus transaction, so it is
    // remembered in drop_q and applied when the response arrives.
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = accept_target;
            end
            S_REQ: begin
                if (flush_i)   drop_d  = 1'b1;
                if (req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flush_i) drop_d = 1'b1;
                if (rsp_valid) begin
                    state_d = (drop_q || flush_i) ? S_IDLE : S_HOLD;
                    drop_d  = 1'b0;
                end
            end
            S_HOLD: begin
                if (flush_i)        state_d = S_IDLE;
                else if (accept)    state_d = accept_target;
                else if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = !flush_i && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
        out_valid = (state_q == S_HOLD);
        req_valid = (state_q == S_REQ);
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            is_load_q        <= 1'b0;
            mask_q           <= 3'b000;
            addr_lo_q        <= 2'b00;
            req_wen_q        <= 1'b0;
            req_addr_q       <= 32'h0;
            req_wdata_q      <= 32'h0;
            req_wstrb_q      <= 4'h0;
            wdata_gpr_q      <= 32'h0;
            gpr_write_q      <= 1'b0;
            gpr_write_addr_q <= 4'h0;
            csr_write_q      <= 1'b0;
            csr_write_addr_q <= 12'h0;
            wdata_csr_q      <= 32'h0;
            is_break_q       <= 1'b0;
            exc_q            <= 1'b0;
            exc_code_q       <= 4'h0;
        end else if (accept) begin
            is_load_q        <= is_load_in;
            mask_q           <= Mem_Mask_i;
            addr_lo_q        <= alu_result_i[1:0];
            req_wen_q        <= !is_load_in;
            req_addr_q       <= {alu_result_i[31:2], 2'b00};
            req_wdata_q      <= st_wdata;
            req_wstrb_q      <= is_load_in ? 4'h0 : st_wstrb;
            wdata_gpr_q      <= wdata_gpr_i;
            gpr_write_q      <= Gpr_Write_i && !mis_exc;
            gpr_write_addr_q <= Gpr_Write_Addr_i;
            csr_write_q      <= Csr_Write_i && !mis_exc;
            csr_write_addr_q <= Csr_Write_Addr_i;
            wdata_csr_q      <= wdata_csr_i;
            is_break_q       <= is_break_i;
            exc_q            <= mis_exc;
            exc_code_q       <= !mis_exc  ? 4'h0 :
                                is_load_in ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
        end else if (rsp_fire) begin
            if (rsp_err) begin
                exc_q       <= 1'b1;
                exc_code_q  <= is_load_q ? EXC_LOAD_FAULT : EXC_STORE_FAULT;
                gpr_write_q <= 1'b0;
                csr_write_q <= 1'b0;
            end else if (is_load_q) begin
                wdata_gpr_q <= ld_data;
            end
        end
    end

    assign req_wen          = req_wen_q;
    assign req_addr         = req_addr_q;
    assign req_wdata        = req_wdata_q;
    assign req_wstrb        = req_wstrb_q;
    assign wdata_gpr_o      = wdata_gpr_q;
    assign Gpr_Write_o      = gpr_write_q;
    assign Gpr_Write_Addr_o = gpr_write_addr_q;
    assign Csr_Write_o      = csr_write_q;
    assign Csr_Write_Addr_o = csr_write_addr_q;
    assign wdata_csr_o      = wdata_csr_q;
    assign is_break_o       = is_break_q;
    assign exc_o            = exc_q;
    assign exc_code_o       = exc_code_q;

endmodule

// File: tb/tb_ysyx_24100006_memu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24100006_memu
// Directed testbench for the MEM stage. Inputs change #1 after a rising edge
// or on the falling edge; outputs are sampled #1 after the rising edge.
// ----------------------------------------------------------------------------
module tb_ysyx_24100006_memu;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_i;
    logic [1:0]  sram_read_write_i;
    logic [2:0]  Mem_Mask_i;
    logic [31:0] wdata_gpr_i;
    logic [31:0] wdata_csr_i;
    logic        Gpr_Write_i;
    logic [3:0]  Gpr_Write_Addr_i;
    logic        Csr_Write_i;
    logic [11:0] Csr_Write_Addr_i;
    logic        is_break_i;
    logic        flush_i;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wdata_gpr_o;
    logic        Gpr_Write_o;
    logic [3:0]  Gpr_Write_Addr_o;
    logic        Csr_Write_o;
    logic [11:0] Csr_Write_Addr_o;
    logic [31:0] wdata_csr_o;
    logic        is_break_o;
    logic        exc_o;
    logic [3:0]  exc_code_o;

    int tests_run    = 0;
    int tests_failed = 0;

    ysyx_24100006_memu dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .alu_result_i      (alu_result_i),
        .sram_read_write_i (sram_read_write_i),
        .Mem_Mask_i        (Mem_Mask_i),
        .wdata_gpr_i       (wdata_gpr_i),
        .wdata_csr_i       (wdata_csr_i),
        .Gpr_Write_i       (Gpr_Write_i),
        .Gpr_Write_Addr_i  (Gpr_Write_Addr_i),
        .Csr_Write_i       (Csr_Write_i),
        .Csr_Write_Addr_i  (Csr_Write_Addr_i),
        .is_break_i        (is_break_i),
        .flush_i           (flush_i),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_wen           (req_wen),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wstrb         (req_wstrb),
        .rsp_valid         (rsp_valid),
        .rsp_rdata         (rsp_rdata),
        .rsp_err           (rsp_err),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .wdata_gpr_o       (wdata_gpr_o),
        .Gpr_Write_o       (Gpr_Write_o),
        .Gpr_Write_Addr_o  (Gpr_Write_Addr_o),
        .Csr_Write_o       (Csr_Write_o),
        .Csr_Write_Addr_o  (Csr_Write_Addr_o),
        .wdata_csr_o       (wdata_csr_o),
        .is_break_o        (is_break_o),
        .exc_o             (exc_o),
        .exc_code_o        (exc_code_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Present one instruction and return #1 after the edge that accepts it.
    task automatic send(input logic [1:0] op, input logic [2:0] mask,
                        input logic [31:0] addr, input logic [31:0] wd);
        int n;
        n = 0;
        @(negedge clk);
        in_valid          = 1'b1;
        sram_read_write_i = op;
        Mem_Mask_i        = mask;
        alu_result_i      = addr;
        wdata_gpr_i       = wd;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Complete one bus transaction: request handshake, then a response one
    // cycle later. Returns #1 after the edge that consumes the response.
    task automatic bus_cycle(input logic [31:0] rdata, input logic err);
        int n;
        n = 0;
        while (!req_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bus_req_valid", 32'(req_valid), 32'd1);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        check("bus_wait_no_out", 32'(out_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_rdata = rdata;
        rsp_err   = err;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
    endtask

    task automatic take_output();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) check("take_timeout", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] mask, input logic [31:0] addr,
                             input logic [31:0] rdata, input logic [31:0] exp);
        send(OP_LOAD, mask, addr, 32'h0);
        check({tag, "_addr"}, req_addr, {addr[31:2], 2'b00});
        check({tag, "_wen"}, 32'(req_wen), 32'd0);
        bus_cycle(rdata, 1'b0);
        check({tag, "_ovalid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, wdata_gpr_o, exp);
        take_output();
    endtask

    initial begin
        reset             = 1'b0;
        in_valid          = 1'b0;
        alu_result_i      = 32'h0;
        sram_read_write_i = OP_NONE;
        Mem_Mask_i        = 3'b000;
        wdata_gpr_i       = 32'h0;
        wdata_csr_i       = 32'hC0FF_EE00;
        Gpr_Write_i       = 1'b1;
        Gpr_Write_Addr_i  = 4'd5;
        Csr_Write_i       = 1'b1;
        Csr_Write_Addr_i  = 12'h305;
        is_break_i        = 1'b0;
        flush_i           = 1'b0;
        req_ready         = 1'b0;
        rsp_valid         = 1'b0;
        rsp_rdata         = 32'h0;
        rsp_err           = 1'b0;
        out_ready         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_exc", 32'(exc_o), 32'd0);
        check("rst_wdata_gpr", wdata_gpr_o, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // LW, no stalls: accept N, req N+1, rsp N+2, out_valid N+3
        send(OP_LOAD, 3'b010, 32'h8000_0004, 32'h0);
        check("lw_req_valid", 32'(req_valid), 32'd1);
        check("lw_req_addr", req_addr, 32'h8000_0004);
        check("lw_req_wen", 32'(req_wen), 32'd0);
        check("lw_no_out_in_req", 32'(out_valid), 32'd0);
        bus_cycle(32'hDEAD_BEEF, 1'b0);
        check("lw_out_valid", 32'(out_valid), 32'd1);
        check("lw_data", wdata_gpr_o, 32'hDEAD_BEEF);
        check("lw_exc", 32'(exc_o), 32'd0);
        check("lw_gpr_we", 32'(Gpr_Write_o), 32'd1);
        check("lw_csr_addr", 32'(Csr_Write_Addr_o), 32'h305);
        check("lw_wdata_csr", wdata_csr_o, 32'hC0FF_EE00);
        take_output();
        check("lw_idle", 32'(out_valid), 32'd0);

        // Sub-word loads
        load_case("lb",  3'b000, 32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80);
        load_case("lbu", 3'b100, 32'h8000_0003, 32'h80FF_1234, 32'h0000_0080);
        load_case("lh",  3'b001, 32'h8000_0002, 32'h80FF_1234, 32'hFFFF_80FF);
        load_case("lhu", 3'b101, 32'h8000_0000, 32'h80FF_9234, 32'h0000_9234);

        // SH at offset 2
        send(OP_STORE, 3'b001, 32'h8000_0002, 32'h0000_ABCD);
        check("sh_wen", 32'(req_wen), 32'd1);
        check("sh_wstrb", 32'(req_wstrb), 32'b1100);
        check("sh_wdata", req_wdata, 32'hABCD_ABCD);
        check("sh_addr", req_addr, 32'h8000_0000);
        bus_cycle(32'h0, 1'b0);
        check("sh_exc", 32'(exc_o), 32'd0);
        check("sh_pass_data", wdata_gpr_o, 32'h0000_ABCD);
        take_output();

        // SB at offset 1
        send(OP_STORE, 3'b000, 32'h8000_0011, 32'h1234_5678);
        check("sb_wstrb", 32'(req_wstrb), 32'b0010);
        check("sb_wdata", req_wdata, 32'h7878_7878);
        bus_cycle(32'h0, 1'b0);
        take_output();

        // Misaligned LW: no bus request, exception 4
        send(OP_LOAD, 3'b010, 32'h8000_0002, 32'h0);
        check("lwmis_req_valid", 32'(req_valid), 32'd0);
        check("lwmis_out_valid", 32'(out_valid), 32'd1);
        check("lwmis_exc", 32'(exc_o), 32'd1);
        check("lwmis_code", 32'(exc_code_o), 32'd4);
        check("lwmis_gpr_we", 32'(Gpr_Write_o), 32'd0);
        check("lwmis_csr_we", 32'(Csr_Write_o), 32'd0);
        take_output();

        // SW with bus error: exception 7
        send(OP_STORE, 3'b010, 32'h8000_0008, 32'h5555_AAAA);
        check("swerr_wstrb", 32'(req_wstrb), 32'hF);
        bus_cycle(32'h0, 1'b1);
        check("swerr_exc", 32'(exc_o), 32'd1);
        check("swerr_code", 32'(exc_code_o), 32'd7);
        check("swerr_gpr_we", 32'(Gpr_Write_o), 32'd0);
        take_output();

        // LH with bus error: exception 5
        send(OP_LOAD, 3'b001, 32'h8000_000C, 32'h0);
        bus_cycle(32'hFFFF_FFFF, 1'b1);
        check("lherr_code", 32'(exc_code_o), 32'd5);
        take_output();

        // Reserved op behaves as none
        send(OP_RSVD, 3'b010, 32'h8000_0001, 32'h0000_0042);
        check("rsvd_req_valid", 32'(req_valid), 32'd0);
        check("rsvd_out_valid", 32'(out_valid), 32'd1);
        check("rsvd_exc", 32'(exc_o), 32'd0);
        check("rsvd_data", wdata_gpr_o, 32'h0000_0042);
        take_output();

        // Back-to-back non-memory ops with out_ready stalled for 3 cycles
        Gpr_Write_Addr_i = 4'd3;
        send(OP_NONE, 3'b000, 32'h0, 32'h0000_0011);
        in_valid          = 1'b1;
        sram_read_write_i = OP_NONE;
        wdata_gpr_i       = 32'h0000_0022;
        Gpr_Write_Addr_i  = 4'd9;
        for (int i = 0; i < 3; i++) begin
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_data", wdata_gpr_o, 32'h0000_0011);
            check("stall_gaddr", 32'(Gpr_Write_Addr_o), 32'd3);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_second_valid", 32'(out_valid), 32'd1);
        check("b2b_second_data", wdata_gpr_o, 32'h0000_0022);
        check("b2b_second_gaddr", 32'(Gpr_Write_Addr_o), 32'd9);
        take_output();
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Flush while waiting for the response
        send(OP_LOAD, 3'b010, 32'h8000_0020, 32'h0);
        req_ready = 1'b1;
        @(posedge clk);
        #1;
        req_ready = 1'b0;
        flush_i   = 1'b1;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        flush_i   = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1111_2222;
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        check("flush_no_out", 32'(out_valid), 32'd0);
        check("flush_in_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("flush_stays_quiet", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-transaction
        send(OP_LOAD, 3'b010, 32'h8000_0040, 32'h0);
        check("rst_mid_req", 32'(req_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_req_drop", 32'(req_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_addr_clr", req_addr, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Normal operation resumes after reset
        load_case("post_rst_lw", 3'b010, 32'h8000_0050, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
